// File: rtl/rv32i_control_unit.sv
// rv32i_control_unit
// Main instruction decoder for the RV32I single-issue core. Decodes the
// opcode, funct3 and funct7[5] fields of a 32-bit instruction into datapath
// control strobes and a 4-bit ALU operation. All outputs are registered, so
// the decode is a one-cycle stage. An asynchronous reset clears everything to
// a safe NOP state.
//
// Ports
//   clk          in   1   system clock, outputs update on the rising edge
//   rst_n        in   1   asynchronous active-low reset
//   instruction  in   32  instruction word, sampled every rising edge
//   branch       out  1   PC redirect candidate (branches, JAL, JALR)
//   mem_read     out  1   data-memory read enable (loads)
//   mem_to_reg   out  1   writeback mux selects memory data (loads)
//   alu_op       out  4   ALU operation code
//   mem_write    out  1   data-memory write enable (stores)
//   alu_src      out  1   ALU operand B: 0 = rs2, 1 = immediate
//   reg_write    out  1   register-file write enable
module rv32i_control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic [3:0]  alu_op,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write
);

  typedef enum logic [3:0] {
    AluAdd   = 4'h0,
    AluSub   = 4'h1,
    AluSll   = 4'h2,
    AluSlt   = 4'h3,
    AluSltu  = 4'h4,
    AluXor   = 4'h5,
    AluSrl   = 4'h6,
    AluSra   = 4'h7,
    AluOr    = 4'h8,
    AluAnd   = 4'h9,
    AluPassB = 4'hA
  } aluOp_e;

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7b5 = instruction[30];

  logic       branch_d, mem_read_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_write_d;
  aluOp_e     alu_op_d;
  logic       branch_q, mem_read_q, mem_to_reg_q, mem_write_q, alu_src_q, reg_write_q;
  logic [3:0] alu_op_q;

  // Shared funct3 -> ALU map for R-type and I-ALU. The caller decides whether
  // bit 30 may select SUB; SRA/SRL always honours it.
  function automatic aluOp_e arithOp(input logic [2:0] f3, input logic b30, input logic allowSub);
    aluOp_e op;
    case (f3)
      3'b000:  op = (allowSub && b30) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = b30 ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  // Next-state decode. Anything unrecognised, including compressed-style
  // encodings with instruction[1:0] != 2'b11, falls through to the NOP default.
  always_comb begin
    branch_d     = 1'b0;
    mem_read_d   = 1'b0;
    mem_to_reg_d = 1'b0;
    mem_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    reg_write_d  = 1'b0;
    alu_op_d     = AluAdd;
    case (opcode)
      OpRType: begin
        reg_write_d = 1'b1;
        alu_op_d    = arithOp(funct3, funct7b5, 1'b1);
      end
      OpIAlu: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_op_d    = arithOp(funct3, funct7b5, 1'b0);
      end
      OpLoad: begin
        mem_read_d   = 1'b1;
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
      end
      OpStore: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      OpBranch: begin
        branch_d = 1'b1;
        case (funct3)
          3'b000, 3'b001: alu_op_d = AluSub;
          3'b100, 3'b101: alu_op_d = AluSlt;
          3'b110, 3'b111: alu_op_d = AluSltu;
          default:        alu_op_d = AluAdd;
        endcase
      end
      OpLui: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_op_d    = AluPassB;
      end
      OpAuipc: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      OpJal, OpJalr: begin
        branch_d    = 1'b1;
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Decode stage register; reset forces the NOP state without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_op_q     <= 4'h0;
    end else begin
      branch_q     <= branch_d;
      mem_read_q   <= mem_read_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      alu_op_q     <= alu_op_d;
    end
  end

  assign branch     = branch_q;
  assign mem_read   = mem_read_q;
  assign mem_to_reg = mem_to_reg_q;
  assign mem_write  = mem_write_q;
  assign alu_src    = alu_src_q;
  assign reg_write  = reg_write_q;
  assign alu_op     = alu_op_q;

endmodule

// File: tb/tb_rv32i_control_unit.sv
// tb_rv32i_control_unit
// Directed self-checking bench for rv32i_control_unit. Each step drives an
// instruction on the falling edge, pushes the expected control word onto a
// scoreboard queue, then pops and compares it just after the next rising edge.
// Control word layout: {branch, mem_read, mem_to_reg, alu_op[3:0], mem_write,
// alu_src, reg_write}.
module tb_rv32i_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [3:0]  alu_op;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sbEntry_t;

  sbEntry_t sbQ[$];

  rv32i_control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .branch      (branch),
    .mem_read    (mem_read),
    .mem_to_reg  (mem_to_reg),
    .alu_op      (alu_op),
    .mem_write   (mem_write),
    .alu_src     (alu_src),
    .reg_write   (reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ctl(input logic br, input logic mr, input logic m2r,
                                     input logic [3:0] op, input logic mw,
                                     input logic src, input logic rw);
    return {br, mr, m2r, op, mw, src, rw};
  endfunction

  function automatic logic [9:0] observed();
    return {branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write};
  endfunction

  // Compare one value against its expectation and count the result.
  task automatic compareNow(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive an instruction on the falling edge and record what it should decode to.
  task automatic applyStimulus(input string tag, input logic [31:0] instr, input logic [9:0] exp);
    sbEntry_t e;
    @(negedge clk);
    instruction = instr;
    e.tag = tag;
    e.exp = exp;
    sbQ.push_back(e);
  endtask

  // Wait for the capturing edge, then pop the oldest expectation and check it.
  task automatic checkOutput();
    sbEntry_t e;
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      compareNow("scoreboard_empty", 10'h3FF, 10'h000);
    end else begin
      e = sbQ.pop_front();
      compareNow(e.tag, observed(), e.exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] instr, input logic [9:0] exp);
    applyStimulus(tag, instr, exp);
    checkOutput();
  endtask

  initial begin
    rst_n       = 1'b0;
    instruction = 32'h001101B3;
    #12;
    compareNow("reset_initial", observed(), 10'h000);
    @(posedge clk);
    #1;
    compareNow("reset_held_through_edge", observed(), 10'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type
    step("add",  32'h001101B3, ctl(0,0,0,4'h0,0,0,1));
    step("sub",  32'h40110133, ctl(0,0,0,4'h1,0,0,1));
    step("sll",  32'h002091B3, ctl(0,0,0,4'h2,0,0,1));
    step("slt",  32'h0020A1B3, ctl(0,0,0,4'h3,0,0,1));
    step("sltu", 32'h0020B1B3, ctl(0,0,0,4'h4,0,0,1));
    step("xor",  32'h0020C1B3, ctl(0,0,0,4'h5,0,0,1));
    step("srl",  32'h0020D1B3, ctl(0,0,0,4'h6,0,0,1));
    step("sra",  32'h4020D1B3, ctl(0,0,0,4'h7,0,0,1));
    step("or",   32'h0020E1B3, ctl(0,0,0,4'h8,0,0,1));
    step("and",  32'h0020F1B3, ctl(0,0,0,4'h9,0,0,1));
    // I-ALU: bit 30 only matters for the shift-right slot
    step("addi",          32'h00410193, ctl(0,0,0,4'h0,0,1,1));
    step("addi_bit30_set",32'h40410193, ctl(0,0,0,4'h0,0,1,1));
    step("srai",          32'h40115193, ctl(0,0,0,4'h7,0,1,1));
    step("srli",          32'h00115193, ctl(0,0,0,4'h6,0,1,1));
    step("sltiu",         32'h00113193, ctl(0,0,0,4'h4,0,1,1));
    step("andi",          32'h00117193, ctl(0,0,0,4'h9,0,1,1));
    // Memory
    step("sw", 32'h00212123, ctl(0,0,0,4'h0,1,1,0));
    step("lw", 32'h00012183, ctl(0,1,1,4'h0,0,1,1));
    // Branches and jumps
    step("beq",      32'h00410063, ctl(1,0,0,4'h1,0,0,0));
    step("bne",      32'h00411063, ctl(1,0,0,4'h1,0,0,0));
    step("blt",      32'h00414063, ctl(1,0,0,4'h3,0,0,0));
    step("bgeu",     32'h00417063, ctl(1,0,0,4'h4,0,0,0));
    step("br_f3_010",32'h00412063, ctl(1,0,0,4'h0,0,0,0));
    step("jal",      32'h000000EF, ctl(1,0,0,4'h0,0,1,1));
    step("jalr",     32'h000080E7, ctl(1,0,0,4'h0,0,1,1));
    // Upper-immediate
    step("lui",   32'h000010B7, ctl(0,0,0,4'hA,0,1,1));
    step("auipc", 32'h00001097, ctl(0,0,0,4'h0,0,1,1));
    // NOP class
    step("ecall",      32'h00000073, 10'h000);
    step("fence",      32'h0000000F, 10'h000);
    step("low_bits_00",32'h001101B0, 10'h000);
    // Ignored bits: flip everything except [30], [14:12], [6:0] on an ADD
    step("ignored_bits", 32'hBFFF8FB3, ctl(0,0,0,4'h0,0,0,1));
    step("rd_x0_write",  32'h00000033, ctl(0,0,0,4'h0,0,0,1));

    // Mid-stream reset must clear outputs without waiting for a clock
    step("pre_reset_lw", 32'h00012183, ctl(0,1,1,4'h0,0,1,1));
    #2;
    rst_n = 1'b0;
    #1;
    compareNow("async_reset_clear", observed(), 10'h000);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_lui", 32'h000010B7, ctl(0,0,0,4'hA,0,1,1));

    if (sbQ.size() != 0) compareNow("scoreboard_leftover", 10'(sbQ.size()), 10'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
